// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for an NDIG-digit
// common-anode 7-segment display, plus its bcd7seg hex decoder.
// Optional feature macro: SEG_SHADOW_EN (writes are buffered in shadow
// registers and copied to the displayed digits at the frame wrap).

module seg_scan_ctrl #(
    parameter int NDIG      = 8,
    parameter int DIV       = 1000,
    parameter int BLANK_CYC = 2,
    localparam int IW       = $clog2(NDIG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [IW-1:0]   wr_idx,
    input  logic [3:0]      wr_data,
    input  logic [NDIG-1:0] en_mask,
    input  logic [NDIG-1:0] dp_mask,
    output logic [6:0]      seg_n,
    output logic            dp_n,
    output logic [NDIG-1:0] an_n,
    output logic            frame_done
);

    localparam int CW = $clog2(DIV);

    typedef enum logic {
        BLANK,
        SHOW
    } phase_t;

    localparam phase_t SLOT_START = (BLANK_CYC == 0) ? SHOW : BLANK;

    phase_t        state, state_nxt;
    logic [IW-1:0] idx, idx_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          wrap;
    logic          wrap_d;
    logic          wr_ok;
    logic [3:0]    digits [NDIG];
    logic [3:0]    cur_digit;
    logic [6:0]    seg_dec;

    // Write qualification: indices beyond the last digit are dropped
    generate
        if (NDIG == (1 << IW)) begin : g_wr_full
            assign wr_ok = wr_en;
        end else begin : g_wr_range
            assign wr_ok = wr_en && (wr_idx < IW'(NDIG));
        end
    endgenerate

    // Scan state register: slot phase, digit index and in-slot counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SLOT_START;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state: advance counter, step digit at slot end, pick phase
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        wrap      = 1'b0;
        if (cnt == CW'(DIV - 1)) begin
            cnt_nxt   = '0;
            wrap      = (idx == IW'(NDIG - 1));
            idx_nxt   = wrap ? '0 : idx + 1'b1;
            state_nxt = SLOT_START;
        end else begin
            cnt_nxt   = cnt + 1'b1;
            state_nxt = (cnt_nxt < CW'(BLANK_CYC)) ? BLANK : SHOW;
        end
    end

`ifdef SEG_SHADOW_EN
    logic [3:0] shadow     [NDIG];
    logic [3:0] shadow_nxt [NDIG];

    // Shadow image including this cycle's write, so a wrap-cycle write lands
    always_comb begin
        shadow_nxt = shadow;
        if (wr_ok) begin
            shadow_nxt[wr_idx] = wr_data;
        end
    end

    // Shadow capture every cycle; displayed digits refresh only at frame wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NDIG; i++) begin
                shadow[i] <= '0;
                digits[i] <= '0;
            end
        end else begin
            shadow <= shadow_nxt;
            if (wrap) begin
                digits <= shadow_nxt;
            end
        end
    end
`else
    // Direct digit storage: writes are visible immediately
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NDIG; i++) begin
                digits[i] <= '0;
            end
        end else if (wr_ok) begin
            digits[wr_idx] <= wr_data;
        end
    end
`endif

    // Select the digit value for the current slot
    always_comb begin
        cur_digit = digits[idx];
    end

    bcd7seg u_dec (
        .hex (cur_digit),
        .seg (seg_dec)
    );

    // Registered pin drivers; frame_done is delayed twice so it lines up
    // with the outputs for the first cycle of digit 0
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_n      <= 7'h7f;
            dp_n       <= 1'b1;
            an_n       <= '1;
            wrap_d     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            seg_n      <= ~seg_dec;
            dp_n       <= ~dp_mask[idx];
            an_n       <= (state == SHOW && en_mask[idx]) ? ~(NDIG'(1) << idx) : '1;
            wrap_d     <= wrap;
            frame_done <= wrap_d;
        end
    end

endmodule

// bcd7seg: hex 0-F to active-high segments, bit 0 = a .. bit 6 = g
module bcd7seg (
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Combinational hex-to-segment lookup
    always_comb begin
        seg = 7'h00;
        case (hex)
            4'h0: seg = 7'h3f;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5b;
            4'h3: seg = 7'h4f;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6d;
            4'h6: seg = 7'h7d;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7f;
            4'h9: seg = 7'h6f;
            4'ha: seg = 7'h77;
            4'hb: seg = 7'h7c;
            4'hc: seg = 7'h39;
            4'hd: seg = 7'h5e;
            4'he: seg = 7'h79;
            4'hf: seg = 7'h71;
            default: seg = 7'h00;
        endcase
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed testbench for seg_scan_ctrl (NDIG=4, DIV=8, BLANK_CYC=2), plus an
// NDIG=3 instance for out-of-range write indices. Honours SEG_SHADOW_EN.

module tb_seg_scan_ctrl;

    localparam int NDIG  = 4;
    localparam int DIV   = 8;
    localparam int BLK   = 2;
    localparam int FRAME = NDIG * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic       wr_en3 = 1'b0;
    logic [1:0] wr_idx = '0;
    logic [3:0] wr_data = '0;
    logic [3:0] en_mask = '1;
    logic [3:0] dp_mask = '0;
    logic [6:0] seg_n;
    logic       dp_n;
    logic [3:0] an_n;
    logic       frame_done;
    logic [6:0] seg3;
    logic       dp3;
    logic [2:0] an3;
    logic       fd3;

    int tests_run = 0;
    int fails = 0;
    int t = 0;
    logic [3:0] disp [NDIG];

    typedef struct {
        int         eff;
        int         idx;
        logic [3:0] val;
    } wr_t;
    wr_t pend[$];

    always #5 clk = ~clk;

    seg_scan_ctrl #(.NDIG(NDIG), .DIV(DIV), .BLANK_CYC(BLK)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
        .en_mask(en_mask), .dp_mask(dp_mask), .seg_n(seg_n), .dp_n(dp_n),
        .an_n(an_n), .frame_done(frame_done)
    );

    seg_scan_ctrl #(.NDIG(3), .DIV(DIV), .BLANK_CYC(BLK)) dut3 (
        .clk(clk), .rst(rst), .wr_en(wr_en3), .wr_idx(wr_idx), .wr_data(wr_data),
        .en_mask(3'b111), .dp_mask(3'b000), .seg_n(seg3), .dp_n(dp3),
        .an_n(an3), .frame_done(fd3)
    );

    function automatic logic [6:0] seg_of(input logic [3:0] h);
        case (h)
            4'h0: return 7'h3f; 4'h1: return 7'h06; 4'h2: return 7'h5b; 4'h3: return 7'h4f;
            4'h4: return 7'h66; 4'h5: return 7'h6d; 4'h6: return 7'h7d; 4'h7: return 7'h07;
            4'h8: return 7'h7f; 4'h9: return 7'h6f; 4'ha: return 7'h77; 4'hb: return 7'h7c;
            4'hc: return 7'h39; 4'hd: return 7'h5e; 4'he: return 7'h79; default: return 7'h71;
        endcase
    endfunction

    // Expected outputs for scan position tt (cycles since reset release)
    function automatic logic [3:0] exp_an(input int tt);
        int ix;
        ix = (tt / DIV) % NDIG;
        if ((tt % DIV) < BLK || !en_mask[ix]) return 4'hf;
        return ~(4'b0001 << ix);
    endfunction

    function automatic logic [6:0] exp_seg(input int tt);
        return ~seg_of(disp[(tt / DIV) % NDIG]);
    endfunction

    function automatic logic exp_dp(input int tt);
        return ~dp_mask[(tt / DIV) % NDIG];
    endfunction

    function automatic logic exp_fd(input int tt);
        return (tt > 0) && (tt % FRAME == 0);
    endfunction

    // One clock: drop strobes, bump position, retire writes now visible
    task automatic advance();
        wr_t keep[$];
        @(negedge clk);
        wr_en  = 1'b0;
        wr_en3 = 1'b0;
        t++;
        keep = {};
        foreach (pend[i]) begin
            if (pend[i].eff <= t) disp[pend[i].idx] = pend[i].val;
            else keep.push_back(pend[i]);
        end
        pend = keep;
    endtask

    // Drive a write for the coming edge and record when it should appear
    task automatic write_digit(input int i, input logic [3:0] v);
        wr_t w;
        wr_en   = 1'b1;
        wr_idx  = 2'(i);
        wr_data = v;
        w.idx = i;
        w.val = v;
`ifdef SEG_SHADOW_EN
        w.eff = ((t + 2 + FRAME - 1) / FRAME) * FRAME;
`else
        w.eff = t + 2;
`endif
        pend.push_back(w);
    endtask

    task automatic release_reset();
        rst = 1'b0;
        t = -1;
        pend = {};
        for (int i = 0; i < NDIG; i++) disp[i] = 4'h0;
        advance();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests_run += 4;
        if (an_n !== 4'hf) begin fails++; $display("FAIL reset_an: got %h exp f", an_n); end
        if (seg_n !== 7'h7f) begin fails++; $display("FAIL reset_seg: got %h exp 7f", seg_n); end
        if (dp_n !== 1'b1) begin fails++; $display("FAIL reset_dp: got %b exp 1", dp_n); end
        if (frame_done !== 1'b0) begin fails++; $display("FAIL reset_fd: got %b exp 0", frame_done); end
        release_reset();
        tests_run += 2;
        if (seg_n !== 7'h40) begin fails++; $display("FAIL run_seg0: got %h exp 40", seg_n); end
        if (dp_n !== 1'b1) begin fails++; $display("FAIL run_dp0: got %b exp 1", dp_n); end
        for (int i = 0; i < FRAME; i++) begin
            tests_run++;
            if (an_n !== exp_an(t)) begin
                fails++; $display("FAIL scan_an t=%0d: got %h exp %h", t, an_n, exp_an(t));
            end
            advance();
        end
    endtask

    task automatic test_frame_done();
        int pulses, exp_pulses, last;
        pulses = 0; exp_pulses = 0; last = -1;
        for (int i = 0; i < 200; i++) begin
            tests_run++;
            if (frame_done !== exp_fd(t)) begin
                fails++; $display("FAIL frame_done t=%0d: got %b exp %b", t, frame_done, exp_fd(t));
            end
            if (exp_fd(t)) exp_pulses++;
            if (frame_done === 1'b1) begin
                pulses++;
                tests_run++;
                if (an_n !== 4'hf) begin fails++; $display("FAIL fd_an t=%0d: got %h exp f", t, an_n); end
                if (last >= 0) begin
                    tests_run++;
                    if (t - last != FRAME) begin
                        fails++; $display("FAIL fd_period: got %0d exp %0d", t - last, FRAME);
                    end
                end
                last = t;
            end
            advance();
        end
        tests_run++;
        if (pulses != exp_pulses) begin
            fails++; $display("FAIL fd_count: got %0d exp %0d", pulses, exp_pulses);
        end
    endtask

    task automatic test_write();
        en_mask = 4'b1111;
        dp_mask = 4'b0000;
        write_digit(3, 4'ha);
        advance();
        write_digit(1, 4'h1);
        advance();
        for (int i = 0; i < 2 * FRAME; i++) begin
            tests_run++;
            if (seg_n !== exp_seg(t)) begin
                fails++; $display("FAIL write_seg t=%0d: got %h exp %h", t, seg_n, exp_seg(t));
            end
            if (pend.size() == 0 && an_n == 4'h7) begin
                tests_run++;
                if (seg_n !== 7'h08) begin fails++; $display("FAIL slot3_A: got %h exp 08", seg_n); end
            end
            if (pend.size() == 0 && an_n == 4'hd) begin
                tests_run++;
                if (seg_n !== 7'h79) begin fails++; $display("FAIL slot1_1: got %h exp 79", seg_n); end
            end
            advance();
        end
    endtask

    task automatic test_out_of_range();
        int shown;
        shown = 0;
        wr_en3  = 1'b1;
        wr_idx  = 2'd3;
        wr_data = 4'h5;
        advance();
        for (int i = 0; i < 40; i++) begin
            if (an3 != 3'b111) begin
                shown++;
                tests_run++;
                if (seg3 !== 7'h40) begin fails++; $display("FAIL oor_seg t=%0d: got %h exp 40", t, seg3); end
            end
            advance();
        end
        tests_run++;
        if (shown == 0) begin fails++; $display("FAIL oor_shown: got 0 exp >0"); end
    endtask

    task automatic test_masks();
        en_mask = 4'b1011;
        dp_mask = 4'b0001;
        advance();
        for (int i = 0; i < 2 * FRAME; i++) begin
            tests_run += 3;
            if (an_n !== exp_an(t)) begin fails++; $display("FAIL mask_an t=%0d: got %h exp %h", t, an_n, exp_an(t)); end
            if (an_n === 4'hb) begin fails++; $display("FAIL mask_dark2 t=%0d: got b exp not b", t); end
            if (dp_n !== exp_dp(t)) begin fails++; $display("FAIL mask_dp t=%0d: got %b exp %b", t, dp_n, exp_dp(t)); end
            if (dp_n === 1'b0 && an_n !== 4'he && an_n !== 4'hf) begin
                tests_run++;
                fails++; $display("FAIL dp_anode t=%0d: got an %h exp e", t, an_n);
            end
            advance();
        end
        en_mask = 4'b1111;
        dp_mask = 4'b0000;
        advance();
    endtask

    task automatic test_reset_midscan();
        for (int i = 0; i < 2 * FRAME; i++) begin
            if ((t % FRAME) == 2 * DIV + 4) break;
            advance();
        end
        tests_run++;
        if ((t % FRAME) != 2 * DIV + 4) begin fails++; $display("FAIL mid_align: got %0d exp %0d", t % FRAME, 2 * DIV + 4); end
        rst = 1'b1;
        @(negedge clk);
        tests_run += 4;
        if (an_n !== 4'hf) begin fails++; $display("FAIL mid_an: got %h exp f", an_n); end
        if (seg_n !== 7'h7f) begin fails++; $display("FAIL mid_seg: got %h exp 7f", seg_n); end
        if (dp_n !== 1'b1) begin fails++; $display("FAIL mid_dp: got %b exp 1", dp_n); end
        if (frame_done !== 1'b0) begin fails++; $display("FAIL mid_fd: got %b exp 0", frame_done); end
        release_reset();
        for (int i = 0; i < FRAME + 8; i++) begin
            tests_run += 2;
            if (seg_n !== 7'h40) begin fails++; $display("FAIL mid_zero t=%0d: got %h exp 40", t, seg_n); end
            if (frame_done !== (t == FRAME)) begin
                fails++; $display("FAIL mid_first_fd t=%0d: got %b exp %b", t, frame_done, t == FRAME);
            end
            advance();
        end
    endtask

`ifdef SEG_SHADOW_EN
    task automatic test_shadow();
        while (t < FRAME + DIV + 2) advance();
        write_digit(0, 4'h8);
        advance();
        write_digit(2, 4'h8);
        advance();
        while (t < 3 * FRAME + 8) begin
            tests_run++;
            if (seg_n !== exp_seg(t)) begin fails++; $display("FAIL sh_seg t=%0d: got %h exp %h", t, seg_n, exp_seg(t)); end
            if (t >= FRAME + 2 * DIV + BLK && t < FRAME + 3 * DIV) begin
                tests_run++;
                if (seg_n !== 7'h40) begin fails++; $display("FAIL sh_tear t=%0d: got %h exp 40", t, seg_n); end
            end
            if (t >= 2 * FRAME + BLK && t < 2 * FRAME + DIV) begin
                tests_run++;
                if (seg_n !== 7'h00 || an_n !== 4'he) begin
                    fails++; $display("FAIL sh_next t=%0d: got %h/%h exp 00/e", t, seg_n, an_n);
                end
            end
            if (t >= 2 * FRAME + DIV + BLK && t < 2 * FRAME + 2 * DIV) begin
                tests_run++;
                if (seg_n !== 7'h30) begin fails++; $display("FAIL sh_wrapwr t=%0d: got %h exp 30", t, seg_n); end
            end
            if (t == 2 * FRAME - 2) write_digit(1, 4'h3);
            advance();
        end
    endtask
`else
    task automatic test_immediate();
        while (t < FRAME + 2 * DIV + 3) advance();
        write_digit(2, 4'h8);
        advance();
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (seg_n !== exp_seg(t)) begin fails++; $display("FAIL imm_seg t=%0d: got %h exp %h", t, seg_n, exp_seg(t)); end
            if (t == FRAME + 2 * DIV + 4) begin
                tests_run++;
                if (seg_n !== 7'h40) begin fails++; $display("FAIL imm_old: got %h exp 40", seg_n); end
            end
            if (t == FRAME + 2 * DIV + 5) begin
                tests_run++;
                if (seg_n !== 7'h00 || an_n !== 4'hb) begin
                    fails++; $display("FAIL imm_new: got %h/%h exp 00/b", seg_n, an_n);
                end
            end
            advance();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_frame_done();
        test_write();
        test_out_of_range();
        test_masks();
        test_reset_midscan();
`ifdef SEG_SHADOW_EN
        test_shadow();
`else
        test_immediate();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
